rc5_core: RTL and testbench
===========================

RC5_CORE -- requirements
Module: rc5_core

Interface
REQ-001 SHALL have parameter W, default 32, meaning word width in bits; legal values are 16, 32 and 64.
REQ-002 SHALL have parameter R, default 12, meaning round count; legal range is 1..255.
REQ-003 SHALL have derived localparam T = 2*R+2, meaning the subkey table depth.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port key_we, input, 1 bit: subkey table write strobe.
REQ-007 SHALL have port key_addr, input, clog2(T) bits: subkey index.
REQ-008 SHALL have port key_wdata, input, W bits: subkey value.
REQ-009 SHALL have port key_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-010 SHALL have port in_valid, input, 1 bit: block offered.
REQ-011 SHALL have port in_ready, output, 1 bit: core can accept a block.
REQ-012 SHALL have port in_mode, input, 1 bit: 0 = encrypt, 1 = decrypt.
REQ-013 SHALL have port in_a, input, W bits: word A of the block.
REQ-014 SHALL have port in_b, input, W bits: word B of the block.
REQ-015 SHALL have port out_valid, output, 1 bit: result held.
REQ-016 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-017 SHALL have ports out_a and out_b, output, W bits each: the result words.

Function
REQ-018 SHALL be an FSM with states IDLE, PRE, ROUND, POST, DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-019 SHALL accept a block on a rising edge with in_valid&&in_ready, registering A, B and mode, and clearing the round counter.
REQ-020 SHALL run encrypt as PRE (A+=S[0], B+=S[1]), then R ROUND cycles i=1..R: A=((A^B)<<<B)+S[2i]; B=((B^A)<<<A)+S[2i+1], with B using the new A.
REQ-021 SHALL run decrypt as R ROUND cycles i=R..1: B=((B-S[2i+1])>>>A)^A; A=((A-S[2i])>>>B)^B, with A using the new B; then POST (B-=S[1], A-=S[0]).
REQ-022 SHALL take the rotate amount from the low log2(W) bits of the operand, and SHALL perform all add/subtract modulo 2^W.
REQ-023 SHALL raise out_valid exactly R+1 edges after the accepting edge, for either mode.
REQ-024 SHALL hold out_a/out_b stable while out_valid && !out_ready.
REQ-025 SHALL return DONE->IDLE on the edge where out_ready=1; a new block SHALL NOT be accepted on that same edge; the earliest acceptance is the following edge.
REQ-026 SHALL store the subkey table as T registers and accept writes only in IDLE.
REQ-027 SHALL ignore a write while busy (not IDLE) or with key_addr>=T, pulsing key_err for 1 cycle; the table SHALL be unchanged.
REQ-028 SHALL, when key_we and an accepted in_valid occur on the same edge, commit the write first; the block SHALL use the new value.
REQ-029 SHALL deassert out_valid and ignore out_ready in any state other than DONE.

Reset
REQ-030 SHALL, on rst=0 regardless of clk, force state IDLE, A=B=0, round counter=0, out_valid=0, key_err=0, out_a=out_b=0.
REQ-031 SHALL clear the subkey table to 0 on reset.
REQ-032 SHALL abort any block in progress on reset mid-operation; no out_valid follows.
REQ-033 SHALL release in_ready=1 on the first edge after rst deasserts.

Structure
REQ-034 SHALL place state encoding, mode constants and the P/Q magic constants per W (for the bench key-expansion model) in shared package rc5_pkg.
REQ-035 SHALL implement one round datapath sub-module, rc5_round (combinational, parametrised by W and direction), instantiated once and reused each cycle.
REQ-036 SHALL NOT perform key expansion; the processor or bench loads S.

Verification
REQ-037 SHALL cover: W=32, R=12, all-zero-key S table, encrypt A=0, B=0 -> out_a=0xEEDBA521, out_b=0x6D8F4B15, with out_valid on edge 13.
REQ-038 SHALL cover: decrypt of the REQ-037 result -> 0x00000000/0x00000000; then decrypt 0xA2B568BA/0xC7EDC2C1 and re-encrypt -> original restored.
REQ-039 SHALL cover: out_ready held 0 for 5 cycles -> outputs stable, in_ready=0, no second accept.
REQ-040 SHALL cover: key_we during ROUND, and key_addr=T in IDLE -> key_err pulse each time, with subsequent encrypt output unchanged.
REQ-041 SHALL cover: rst=0 asserted mid-ROUND between edges -> outputs zero immediately, no out_valid, and the next block correct.
REQ-042 SHALL cover: W=16, R=8 and W=64, R=20 random blocks -> encrypt-then-decrypt identity and match against the rc5_pkg-based model.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: FSM states, mode encoding and the P/Q magic
// constants used by key expansion for each supported word width.
package rc5_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ROUND,
        POST,
        DONE
    } rc5_state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic logic [63:0] rc5_p(input int unsigned w);
        case (w)
            16:      return 64'h0000_0000_0000_B7E1;
            32:      return 64'h0000_0000_B7E1_5163;
            default: return 64'hB7E1_5162_8AED_2A6B;
        endcase
    endfunction

    function automatic logic [63:0] rc5_q(input int unsigned w);
        case (w)
            16:      return 64'h0000_0000_0000_9E37;
            32:      return 64'h0000_0000_9E37_79B9;
            default: return 64'h9E37_79B9_7F4A_7C15;
        endcase
    endfunction

endpackage

// File: rtl/rc5_round.sv
// One RC5 half-round pair (both words) in either direction; purely combinational.
module rc5_round #(
    parameter int W = 32
) (
    input  logic         dec,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [W-1:0] s_a,
    input  logic [W-1:0] s_b,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out
);

    localparam int L = $clog2(W);

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [L-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [L-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

    // The second word of each direction depends on the freshly updated first word.
    always_comb begin
        a_out = a_in;
        b_out = b_in;
        if (!dec) begin
            a_out = rotl(a_in ^ b_in, b_in[L-1:0]) + s_a;
            b_out = rotl(b_in ^ a_out, a_out[L-1:0]) + s_b;
        end else begin
            b_out = rotr(b_in - s_b, a_in[L-1:0]) ^ a_in;
            a_out = rotr(a_in - s_a, b_out[L-1:0]) ^ b_out;
        end
    end

endmodule

// File: rtl/rc5_core.sv
// Iterative RC5 encrypt/decrypt core: one round per clock, externally loaded
// subkey table, valid/ready handshake on both sides.
module rc5_core
    import rc5_pkg::*;
#(
    parameter  int W  = 32,
    parameter  int R  = 12,
    localparam int T  = 2 * R + 2,
    localparam int AW = $clog2(T)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_we,
    input  logic [AW-1:0] key_addr,
    input  logic [W-1:0]  key_wdata,
    output logic          key_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b
);

    rc5_state_e   state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic         mode_q, mode_d;
    logic [7:0]   rnd_q, rnd_d;
    logic         key_err_q, key_err_d;
    logic [W-1:0] s_q [T];
    logic [W-1:0] s_d [T];

    logic [8:0]    rnd_i;
    logic [AW-1:0] idx_a, idx_b;
    logic [W-1:0]  rnd_a, rnd_b;
    logic          addr_ok;

    // Round index runs 1..R for encrypt and R..1 for decrypt from one up-counter.
    assign rnd_i   = (mode_q == MODE_DEC) ? (9'(R) - {1'b0, rnd_q}) : ({1'b0, rnd_q} + 9'd1);
    assign idx_a   = AW'({rnd_i, 1'b0});
    assign idx_b   = AW'({rnd_i, 1'b1});
    assign addr_ok = ({1'b0, key_addr} < (AW+1)'(T));

    rc5_round #(.W(W)) u_round (
        .dec   (mode_q),
        .a_in  (a_q),
        .b_in  (b_q),
        .s_a   (s_q[idx_a]),
        .s_b   (s_q[idx_b]),
        .a_out (rnd_a),
        .b_out (rnd_b)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        rnd_d     = rnd_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        key_err_d = 1'b0;
        s_d       = s_q;

        if (key_we) begin
            if (state_q == IDLE && addr_ok) s_d[key_addr] = key_wdata;
            else                            key_err_d     = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    mode_d  = in_mode;
                    rnd_d   = '0;
                    state_d = (in_mode == MODE_ENC) ? PRE : ROUND;
                end
            end
            PRE: begin
                a_d     = a_q + s_q[0];
                b_d     = b_q + s_q[1];
                state_d = ROUND;
            end
            ROUND: begin
                a_d   = rnd_a;
                b_d   = rnd_b;
                rnd_d = rnd_q + 8'd1;
                if (rnd_q == 8'(R - 1)) begin
                    if (mode_q == MODE_DEC) begin
                        state_d = POST;
                    end else begin
                        out_a_d = rnd_a;
                        out_b_d = rnd_b;
                        state_d = DONE;
                    end
                end
            end
            POST: begin
                a_d     = a_q - s_q[0];
                b_d     = b_q - s_q[1];
                out_a_d = a_q - s_q[0];
                out_b_d = b_q - s_q[1];
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= MODE_ENC;
            rnd_q     <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            key_err_q <= 1'b0;
            for (int unsigned i = 0; i < T; i++) s_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mode_q    <= mode_d;
            rnd_q     <= rnd_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            key_err_q <= key_err_d;
            for (int unsigned i = 0; i < T; i++) s_q[i] <= s_d[i];
        end
    end

    assign key_err   = key_err_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

endmodule

// File: tb/tb_rc5_core.sv
// Self-checking bench for rc5_core at W=32/R=12, W=16/R=8 and W=64/R=20,
// with an independent key-expansion and cipher model.
module tb_rc5_core;
    import rc5_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        key_we_g;
    logic [5:0]  key_addr_g;
    logic [63:0] key_wdata_g;
    logic        in_valid_g, in_mode_g, out_ready_g;
    logic [63:0] in_a_g, in_b_g;
    int          sel;

    logic we32, iv32, kerr32, irdy32, oval32;
    logic we16, iv16, kerr16, irdy16, oval16;
    logic we64, iv64, kerr64, irdy64, oval64;
    logic [31:0] oa32, ob32;
    logic [15:0] oa16, ob16;
    logic [63:0] oa64, ob64;

    assign we32 = key_we_g && (sel == 0);
    assign iv32 = in_valid_g && (sel == 0);
    assign we16 = key_we_g && (sel == 1);
    assign iv16 = in_valid_g && (sel == 1);
    assign we64 = key_we_g && (sel == 2);
    assign iv64 = in_valid_g && (sel == 2);

    rc5_core #(.W(32), .R(12)) u_dut32 (
        .clk(clk), .rst(rst_n), .key_we(we32), .key_addr(key_addr_g[4:0]),
        .key_wdata(key_wdata_g[31:0]), .key_err(kerr32), .in_valid(iv32),
        .in_ready(irdy32), .in_mode(in_mode_g), .in_a(in_a_g[31:0]), .in_b(in_b_g[31:0]),
        .out_valid(oval32), .out_ready(out_ready_g), .out_a(oa32), .out_b(ob32));

    rc5_core #(.W(16), .R(8)) u_dut16 (
        .clk(clk), .rst(rst_n), .key_we(we16), .key_addr(key_addr_g[4:0]),
        .key_wdata(key_wdata_g[15:0]), .key_err(kerr16), .in_valid(iv16),
        .in_ready(irdy16), .in_mode(in_mode_g), .in_a(in_a_g[15:0]), .in_b(in_b_g[15:0]),
        .out_valid(oval16), .out_ready(out_ready_g), .out_a(oa16), .out_b(ob16));

    rc5_core #(.W(64), .R(20)) u_dut64 (
        .clk(clk), .rst(rst_n), .key_we(we64), .key_addr(key_addr_g),
        .key_wdata(key_wdata_g), .key_err(kerr64), .in_valid(iv64),
        .in_ready(irdy64), .in_mode(in_mode_g), .in_a(in_a_g), .in_b(in_b_g),
        .out_valid(oval64), .out_ready(out_ready_g), .out_a(oa64), .out_b(ob64));

    logic        cur_kerr, cur_irdy, cur_oval;
    logic [63:0] cur_oa, cur_ob;
    always_comb begin
        case (sel)
            1: begin
                cur_kerr = kerr16; cur_irdy = irdy16; cur_oval = oval16;
                cur_oa = {48'b0, oa16}; cur_ob = {48'b0, ob16};
            end
            2: begin
                cur_kerr = kerr64; cur_irdy = irdy64; cur_oval = oval64;
                cur_oa = oa64; cur_ob = ob64;
            end
            default: begin
                cur_kerr = kerr32; cur_irdy = irdy32; cur_oval = oval32;
                cur_oa = {32'b0, oa32}; cur_ob = {32'b0, ob32};
            end
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;
    int cur_w, cur_r;
    logic [63:0]  s_exp [64];
    logic [127:0] sb_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] m_rotl(input logic [63:0] x, input logic [63:0] n, input int w);
        int amt;
        logic [63:0] m;
        m = wmask(w);
        x = x & m;
        amt = int'(n[5:0]) % w;
        if (amt == 0) return x;
        return ((x << amt) | (x >> (w - amt))) & m;
    endfunction

    function automatic logic [63:0] m_rotr(input logic [63:0] x, input logic [63:0] n, input int w);
        int amt;
        logic [63:0] m;
        m = wmask(w);
        x = x & m;
        amt = int'(n[5:0]) % w;
        if (amt == 0) return x;
        return ((x >> amt) | (x << (w - amt))) & m;
    endfunction

    // Standard RC5 key schedule for a 16-byte all-zero key.
    task automatic keyexp(input int w, input int r);
        logic [63:0] lk [8];
        logic [63:0] a, b, m;
        int t, c, i, j, n;
        m = wmask(w);
        t = 2 * r + 2;
        c = 16 / (w / 8);
        for (int k = 0; k < 8; k++) lk[k] = '0;
        s_exp[0] = rc5_p(w) & m;
        for (int k = 1; k < t; k++) s_exp[k] = (s_exp[k-1] + rc5_q(w)) & m;
        a = '0; b = '0; i = 0; j = 0;
        n = 3 * ((t > c) ? t : c);
        for (int k = 0; k < n; k++) begin
            a = m_rotl((s_exp[i] + a + b) & m, 64'd3, w);
            s_exp[i] = a;
            b = m_rotl((lk[j] + a + b) & m, (a + b) & m, w);
            lk[j] = b;
            i = (i + 1) % t;
            j = (j + 1) % c;
        end
    endtask

    function automatic logic [127:0] model_enc(input int w, input int r, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        m = wmask(w);
        a = (a + s_exp[0]) & m;
        b = (b + s_exp[1]) & m;
        for (int i = 1; i <= r; i++) begin
            a = (m_rotl(a ^ b, b, w) + s_exp[2*i]) & m;
            b = (m_rotl(b ^ a, a, w) + s_exp[2*i+1]) & m;
        end
        return {a, b};
    endfunction

    function automatic logic [127:0] model_dec(input int w, input int r, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        m = wmask(w);
        for (int i = r; i >= 1; i--) begin
            b = m_rotr((b - s_exp[2*i+1]) & m, a, w) ^ a;
            a = m_rotr((a - s_exp[2*i]) & m, b, w) ^ b;
        end
        b = (b - s_exp[1]) & m;
        a = (a - s_exp[0]) & m;
        return {a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input int t);
        for (int i = 0; i < t; i++) begin
            key_we_g    = 1'b1;
            key_addr_g  = 6'(i);
            key_wdata_g = s_exp[i];
            tick();
        end
        key_we_g = 1'b0;
        check("key_err_on_legal_write", {63'b0, cur_kerr}, 64'd0);
    endtask

    // Wait for out_valid, compare against the scoreboard head, then release.
    task automatic collect(input string name, input int edges0, output logic [127:0] got);
        int edges;
        logic [127:0] exp;
        edges = edges0;
        while (!cur_oval && edges < 2000) begin
            tick();
            edges++;
        end
        check({name, "_latency"}, 64'(edges), 64'(cur_r + 1));
        got = {cur_oa, cur_ob};
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check({name, "_a"}, cur_oa, exp[127:64]);
        check({name, "_b"}, cur_ob, exp[63:0]);
        out_ready_g = 1'b1;
        tick();
        out_ready_g = 1'b0;
        check({name, "_release"}, {63'b0, cur_oval}, 64'd0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!cur_irdy && n < 100) begin
            tick();
            n++;
        end
        if (!cur_irdy) check({name, "_ready_timeout"}, {63'b0, cur_irdy}, 64'd1);
    endtask

    task automatic run_block(input logic mode, input logic [63:0] a, input logic [63:0] b,
                             input logic [127:0] exp, input string name, output logic [127:0] got);
        in_mode_g  = mode;
        in_a_g     = a;
        in_b_g     = b;
        in_valid_g = 1'b1;
        wait_ready(name);
        tick();
        sb_q.push_back(exp);
        in_valid_g = 1'b0;
        collect(name, 0, got);
    endtask

    typedef struct {
        logic         mode;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         vecs [6];
        logic [127:0] got, e;
        logic [63:0]  ra, rb, m, s0_save;
        int           seen;

        rst_n = 1'b0; sel = 0; cur_w = 32; cur_r = 12;
        key_we_g = 1'b0; key_addr_g = '0; key_wdata_g = '0;
        in_valid_g = 1'b0; in_mode_g = 1'b0; in_a_g = '0; in_b_g = '0; out_ready_g = 1'b0;

        #12;
        check("rst_out_valid", {63'b0, cur_oval}, 64'd0);
        check("rst_key_err", {63'b0, cur_kerr}, 64'd0);
        check("rst_out_a", cur_oa, 64'd0);
        check("rst_out_b", cur_ob, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_release_in_ready", {63'b0, cur_irdy}, 64'd1);

        keyexp(32, 12);
        load_keys(26);

        vecs[0] = '{1'b0, 64'h0, 64'h0, {64'hEEDBA521, 64'h6D8F4B15}};
        vecs[1] = '{1'b1, 64'hEEDBA521, 64'h6D8F4B15, 128'h0};
        e = model_dec(32, 12, 64'hA2B568BA, 64'hC7EDC2C1);
        vecs[2] = '{1'b1, 64'hA2B568BA, 64'hC7EDC2C1, e};
        vecs[3] = '{1'b0, e[127:64], e[63:0], {64'hA2B568BA, 64'hC7EDC2C1}};
        ra = 64'($urandom); rb = 64'($urandom);
        vecs[4] = '{1'b0, ra, rb, model_enc(32, 12, ra, rb)};
        ra = 64'($urandom); rb = 64'($urandom);
        vecs[5] = '{1'b1, ra, rb, model_dec(32, 12, ra, rb)};
        for (int i = 0; i < 6; i++) run_block(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("w32_vec%0d", i), got);

        // Consumer stall with a second block already offered.
        in_mode_g = 1'b0; in_a_g = '0; in_b_g = '0; in_valid_g = 1'b1;
        wait_ready("stall");
        tick();
        sb_q.push_back({64'hEEDBA521, 64'h6D8F4B15});
        in_a_g = 64'h12345678; in_b_g = 64'h9ABCDEF0;
        seen = 0;
        while (!cur_oval && seen < 100) begin tick(); seen++; end
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_out_a", cur_oa, e[127:64]);
            check("stall_out_b", cur_ob, e[63:0]);
            check("stall_in_ready", {63'b0, cur_irdy}, 64'd0);
            check("stall_out_valid", {63'b0, cur_oval}, 64'd1);
        end
        out_ready_g = 1'b1;
        tick();
        out_ready_g = 1'b0;
        check("no_accept_on_release_edge", {63'b0, cur_irdy}, 64'd1);
        check("release_out_valid", {63'b0, cur_oval}, 64'd0);
        tick();
        check("accept_next_edge", {63'b0, cur_irdy}, 64'd0);
        in_valid_g = 1'b0;
        sb_q.push_back(model_enc(32, 12, 64'h12345678, 64'h9ABCDEF0));
        collect("stall_second", 0, got);

        // Rejected writes: while busy, and out of range while idle.
        ra = 64'($urandom); rb = 64'($urandom);
        in_mode_g = 1'b0; in_a_g = ra; in_b_g = rb; in_valid_g = 1'b1;
        wait_ready("kerr_busy");
        tick();
        sb_q.push_back(model_enc(32, 12, ra, rb));
        in_valid_g = 1'b0;
        tick();
        tick();
        key_we_g = 1'b1; key_addr_g = 6'd3; key_wdata_g = 64'hDEADBEEF;
        tick();
        key_we_g = 1'b0;
        check("key_err_busy_pulse", {63'b0, cur_kerr}, 64'd1);
        tick();
        check("key_err_busy_clear", {63'b0, cur_kerr}, 64'd0);
        collect("kerr_busy_block", 4, got);
        key_we_g = 1'b1; key_addr_g = 6'd26; key_wdata_g = 64'hFFFFFFFF;
        tick();
        key_we_g = 1'b0;
        check("key_err_range_pulse", {63'b0, cur_kerr}, 64'd1);
        tick();
        check("key_err_range_clear", {63'b0, cur_kerr}, 64'd0);
        run_block(1'b0, 64'h0, 64'h0, {64'hEEDBA521, 64'h6D8F4B15}, "after_rejects", got);

        // Write and accept on the same edge: the block sees the new S[0].
        s0_save = s_exp[0];
        key_we_g = 1'b1; key_addr_g = 6'd0; key_wdata_g = 64'h0BADF00D;
        in_mode_g = 1'b0; in_a_g = 64'h11; in_b_g = 64'h22; in_valid_g = 1'b1;
        wait_ready("same_edge");
        tick();
        key_we_g = 1'b0; in_valid_g = 1'b0;
        check("same_edge_key_err", {63'b0, cur_kerr}, 64'd0);
        s_exp[0] = 64'h0BADF00D;
        sb_q.push_back(model_enc(32, 12, 64'h11, 64'h22));
        collect("same_edge_write", 0, got);
        s_exp[0] = s0_save;
        key_we_g = 1'b1; key_addr_g = 6'd0; key_wdata_g = s0_save;
        tick();
        key_we_g = 1'b0;

        // Asynchronous reset in the middle of the rounds.
        in_mode_g = 1'b0; in_a_g = 64'h5A5A5A5A; in_b_g = 64'hA5A5A5A5; in_valid_g = 1'b1;
        wait_ready("abort");
        tick();
        in_valid_g = 1'b0;
        tick(); tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        check("abort_out_a", cur_oa, 64'd0);
        check("abort_out_b", cur_ob, 64'd0);
        check("abort_out_valid", {63'b0, cur_oval}, 64'd0);
        check("abort_in_ready", {63'b0, cur_irdy}, 64'd1);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cur_oval) seen++;
        end
        check("abort_no_out_valid", 64'(seen), 64'd0);
        for (int k = 0; k < 26; k++) s_exp[k] = '0;
        run_block(1'b0, 64'h5A5A5A5A, 64'hA5A5A5A5, model_enc(32, 12, 64'h5A5A5A5A, 64'hA5A5A5A5), "cleared_table", got);
        keyexp(32, 12);
        load_keys(26);
        run_block(1'b0, 64'h0, 64'h0, {64'hEEDBA521, 64'h6D8F4B15}, "post_reset", got);

        // Other widths: random round trips.
        sel = 1; cur_w = 16; cur_r = 8;
        keyexp(16, 8);
        load_keys(18);
        m = wmask(16);
        for (int k = 0; k < 4; k++) begin
            ra = {$urandom, $urandom} & m; rb = {$urandom, $urandom} & m;
            run_block(1'b0, ra, rb, model_enc(16, 8, ra, rb), "w16_enc", got);
            run_block(1'b1, got[127:64], got[63:0], {ra, rb}, "w16_dec", got);
        end

        sel = 2; cur_w = 64; cur_r = 20;
        keyexp(64, 20);
        load_keys(42);
        for (int k = 0; k < 4; k++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            run_block(1'b0, ra, rb, model_enc(64, 20, ra, rb), "w64_enc", got);
            run_block(1'b1, got[127:64], got[63:0], {ra, rb}, "w64_dec", got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
